// File: rtl/max_row_ctrl.sv
// max_row_ctrl: row scheduler for the running-max stage of the attention
// score pipeline. Scores stream in and are issued to a single-stage `max`
// unit together with the previous running max of their row. The previous
// max is INT_MIN at the start of every row. Results from `max` are forwarded
// downstream with row/last tags, and a job covers num_rows rows of row_len
// scores each.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start              job start pulse (sampled in IDLE only)
//   row_len, num_rows  job geometry, latched on an accepted start
//   s_vld_in/s_rdy_out/s_in                  upstream score stream
//   mx_vld_in/mx_rdy_out/mx_s_in/mx_m_prev_in  issue side of `max`
//   mx_rdy_in/mx_vld_out/mx_m_out/mx_s_out     result side of `max`
//   out_vld/out_rdy/out_s/out_m/out_last/out_row  downstream stream
//   row_max            final max of the last completed row (held)
//   busy, done         job status (busy in RUN/DRAIN, done 1-cycle pulse)
//   state_dbg          current FSM state, for observation only
//
// Handshakes: every stream transfers a beat on a rising clk edge where its
// valid and ready are both high. A valid source keeps valid and data stable
// until that edge; ready may depend combinationally on the downstream ready.
module max_row_ctrl #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 16,
  parameter logic signed [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         row_len,
  input  logic [CNT_W-1:0]         num_rows,
  input  logic                     s_vld_in,
  output logic                     s_rdy_out,
  input  logic signed [DATA_W-1:0] s_in,
  output logic                     mx_vld_in,
  output logic                     mx_rdy_in,
  input  logic                     mx_rdy_out,
  output logic signed [DATA_W-1:0] mx_s_in,
  output logic signed [DATA_W-1:0] mx_m_prev_in,
  input  logic                     mx_vld_out,
  input  logic signed [DATA_W-1:0] mx_m_out,
  input  logic signed [DATA_W-1:0] mx_s_out,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic signed [DATA_W-1:0] out_s,
  output logic signed [DATA_W-1:0] out_m,
  output logic                     out_last,
  output logic [CNT_W-1:0]         out_row,
  output logic signed [DATA_W-1:0] row_max,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] len_q, rows_q;
  logic [CNT_W-1:0] i_col, i_row;
  logic             t_last;
  logic [CNT_W-1:0] t_row;
  logic signed [DATA_W-1:0] m_run;

  logic start_acc, issue, out_hs, col_last, last_issue;

  assign start_acc  = (state_q == IDLE) && start;
  assign s_rdy_out  = mx_rdy_out && (state_q == RUN);
  assign mx_vld_in  = s_vld_in && (state_q == RUN);
  assign issue      = s_vld_in && s_rdy_out;
  assign out_hs     = mx_vld_out && out_rdy;
  assign col_last   = (i_col == len_q - CNT_W'(1));
  assign last_issue = issue && col_last && (i_row == rows_q - CNT_W'(1));

  assign mx_s_in   = s_in;
  assign mx_rdy_in = out_rdy;

  // First column of a row always starts from INT_MIN. Otherwise the entry
  // still inside `max` belongs to the same row, so its result is the newest
  // max and is bypassed ahead of m_run.
  always_comb begin
    mx_m_prev_in = m_run;
    if (i_col == '0)     mx_m_prev_in = INT_MIN;
    else if (mx_vld_out) mx_m_prev_in = mx_m_out;
  end

  assign out_vld  = mx_vld_out;
  assign out_s    = mx_s_out;
  assign out_m    = mx_m_out;
  assign out_last = t_last;
  assign out_row  = t_row;

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (row_len == '0 || num_rows == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        // Only the final entry can be in flight here.
        if (out_hs) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      rows_q  <= '0;
      i_col   <= '0;
      i_row   <= '0;
      t_last  <= 1'b0;
      t_row   <= '0;
      m_run   <= INT_MIN;
      row_max <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        len_q  <= row_len;
        rows_q <= num_rows;
        i_col  <= '0;
        i_row  <= '0;
      end else if (issue) begin
        if (col_last) begin
          i_col <= '0;
          i_row <= i_row + CNT_W'(1);
        end else begin
          i_col <= i_col + CNT_W'(1);
        end
      end
      // Tags track the one entry held in `max`; they advance with issues.
      if (issue) begin
        t_last <= col_last;
        t_row  <= i_row;
      end
      if (out_hs) begin
        m_run <= mx_m_out;
        if (t_last) row_max <= mx_m_out;
      end
    end
  end

endmodule
